// File: rtl/weight_mac_seq.sv
// weight_mac_seq: sequencer and owner of one neuron's weight BRAM.
//
// The weight BRAM and the activation buffer are both read on the falling edge,
// so an address registered at a rising edge returns data at the next rising edge.
// LOAD mode streams DEPTH weights into the BRAM.
// RUN mode sweeps addresses 0..DEPTH-1 and accumulates weight*activation onto a
// sign-extended bias.
//
// Ports:
//   CLK, RST          clock and synchronous active-high reset
//   START, LOAD       commands from the layer controller; LOAD wins
//   LD_VALID/LD_DATA  weight stream in; LD_READY is high while in LOAD
//   BIAS              bias, sampled on the START edge
//   X_ADDR/X_DATA     activation buffer address and data
//   BRAM_*            weight BRAM port (all outputs registered)
//   BUSY              high in LOAD, LDFIN or RUN
//   DONE, LD_DONE     one-cycle completion pulses
//   ACC_OUT           result, held until the next RUN completes
//
// state | meaning
// IDLE  | waiting for LOAD or START
// LOAD  | accepting weights, one BRAM write per valid word
// LDFIN | last write lands in the BRAM; LD_DONE pulse
// RUN   | one accumulate per cycle, addresses 0..DEPTH-1
// FIN   | DONE pulse; accepts a new START/LOAD for back-to-back runs
module weight_mac_seq #(
  parameter int DEPTH = 28,
  parameter int AW    = 5,
  parameter int DW    = 16,
  parameter int ACCW  = 40
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic            START,
  input  logic            LOAD,
  input  logic            LD_VALID,
  input  logic [DW-1:0]   LD_DATA,
  output logic            LD_READY,
  input  logic [DW-1:0]   BIAS,
  output logic [AW-1:0]   X_ADDR,
  input  logic [DW-1:0]   X_DATA,
  output logic [AW-1:0]   BRAM_ADDR,
  output logic [DW-1:0]   BRAM_DI,
  output logic            BRAM_EN,
  output logic            BRAM_WE,
  input  logic [DW-1:0]   BRAM_DO,
  output logic            BUSY,
  output logic            DONE,
  output logic            LD_DONE,
  output logic [ACCW-1:0] ACC_OUT
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_LDFIN = 3'd2,
    S_RUN   = 3'd3,
    S_FIN   = 3'd4
  } state_t;

  localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

  state_t          state_q, state_d;
  logic [AW-1:0]   cnt_q, cnt_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic [DW-1:0]   di_q, di_d;
  logic            en_q, en_d;
  logic            we_q, we_d;
  logic            ld_ready_q, ld_ready_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            ld_done_q, ld_done_d;
  logic [ACCW-1:0] acc_q, acc_d;
  logic [ACCW-1:0] acc_out_q, acc_out_d;

  logic signed [2*DW-1:0] prod;
  logic [ACCW-1:0]        prod_ext;
  logic [ACCW-1:0]        bias_ext;
  logic [ACCW-1:0]        acc_sum;

  always_comb begin
    prod     = $signed(BRAM_DO) * $signed(X_DATA);
    prod_ext = {{(ACCW-2*DW){prod[2*DW-1]}}, prod};
    bias_ext = {{(ACCW-DW){BIAS[DW-1]}}, BIAS};
    acc_sum  = acc_q + prod_ext;

    state_d   = state_q;
    cnt_d     = cnt_q;
    addr_d    = addr_q;
    di_d      = di_q;
    en_d      = en_q;
    we_d      = we_q;
    done_d    = 1'b0;
    ld_done_d = 1'b0;
    acc_d     = acc_q;
    acc_out_d = acc_out_q;

    case (state_q)
      S_IDLE, S_FIN: begin
        en_d = 1'b0;
        we_d = 1'b0;
        if (LOAD) begin
          state_d = S_LOAD;
          cnt_d   = '0;
        end else if (START) begin
          state_d = S_RUN;
          acc_d   = bias_ext;
          en_d    = 1'b1;
          addr_d  = '0;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_LOAD: begin
        if (LD_VALID) begin
          en_d   = 1'b1;
          we_d   = 1'b1;
          addr_d = cnt_q;
          di_d   = LD_DATA;
          cnt_d  = cnt_q + AW'(1);
          if (cnt_q == LAST_ADDR) begin
            state_d   = S_LDFIN;
            ld_done_d = 1'b1;
          end
        end else begin
          en_d = 1'b0;
          we_d = 1'b0;
        end
      end
      S_LDFIN: begin
        en_d    = 1'b0;
        we_d    = 1'b0;
        state_d = S_IDLE;
      end
      S_RUN: begin
        // Data for addr_q - 1 arrives this edge; once the last address has
        // been issued, this edge folds in the final product.
        acc_d = acc_sum;
        if (addr_q == LAST_ADDR) begin
          en_d      = 1'b0;
          state_d   = S_FIN;
          acc_out_d = acc_sum;
          done_d    = 1'b1;
        end else begin
          addr_d = addr_q + AW'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
        en_d    = 1'b0;
        we_d    = 1'b0;
      end
    endcase

    ld_ready_d = (state_d == S_LOAD);
    busy_d     = (state_d == S_LOAD) || (state_d == S_LDFIN) || (state_d == S_RUN);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      addr_q     <= '0;
      di_q       <= '0;
      en_q       <= 1'b0;
      we_q       <= 1'b0;
      ld_ready_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      ld_done_q  <= 1'b0;
      acc_q      <= '0;
      acc_out_q  <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      addr_q     <= addr_d;
      di_q       <= di_d;
      en_q       <= en_d;
      we_q       <= we_d;
      ld_ready_q <= ld_ready_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      ld_done_q  <= ld_done_d;
      acc_q      <= acc_d;
      acc_out_q  <= acc_out_d;
    end
  end

  assign BRAM_ADDR = addr_q;
  assign X_ADDR    = addr_q;
  assign BRAM_DI   = di_q;
  assign BRAM_EN   = en_q;
  assign BRAM_WE   = we_q;
  assign LD_READY  = ld_ready_q;
  assign BUSY      = busy_q;
  assign DONE      = done_q;
  assign LD_DONE   = ld_done_q;
  assign ACC_OUT   = acc_out_q;

endmodule

// File: doc/weight_mac_seq.md
Name: weight_mac_seq

Overview:
- Sequencer and owner of one neuron's weight BRAM (DEPTH x 16-bit, read/written on negedge CLK, EN/WE/ADDR/DI/DO port set).
- Two modes: LOAD streams DEPTH weights into the BRAM; RUN sweeps addresses 0..DEPTH-1, multiplies each weight by the matching activation and accumulates onto a bias.
- Sits between the layer controller (START/LOAD/DONE) and the per-neuron weight BRAM plus the shared activation buffer.

Parameters:
- DEPTH, 28, number of weights / activations per neuron.
- AW, 5, address width; must satisfy 2^AW >= DEPTH.
- DW, 16, weight / activation / bias width, signed two's complement.
- ACCW, 40, accumulator width; must be >= 2*DW + ceil(log2(DEPTH)) + 1.

Ports:
- CLK  in  1  clock; all logic in this block is posedge.
- RST  in  1  synchronous, active-high reset.
- START  in  1  begin RUN; sampled in IDLE or FIN.
- LOAD  in  1  begin LOAD; sampled in IDLE or FIN; wins over START.
- LD_VALID  in  1  LD_DATA valid.
- LD_DATA  in  DW  weight to write.
- LD_READY  out  1  high in LOAD state.
- BIAS  in  DW  sampled on the START edge.
- X_ADDR  out  AW  activation buffer address; equals BRAM_ADDR.
- X_DATA  in  DW  activation, negedge-read buffer, same timing as BRAM_DO.
- BRAM_ADDR  out  AW  weight BRAM address.
- BRAM_DI  out  DW  weight BRAM write data.
- BRAM_EN  out  1  weight BRAM enable.
- BRAM_WE  out  1  weight BRAM write enable.
- BRAM_DO  in  DW  weight BRAM read data.
- BUSY  out  1  high in LOAD, LDFIN or RUN.
- DONE  out  1  one-cycle pulse, RUN complete.
- LD_DONE  out  1  one-cycle pulse, LOAD complete.
- ACC_OUT  out  ACCW  registered result; held until the next RUN completes.

Behaviour:
- Reset values: all outputs 0, state IDLE, address counter 0, accumulator 0.
- All BRAM_* and X_ADDR outputs are registered.
- Memory timing: an address registered at posedge t is read by the BRAM at the following negedge, so BRAM_DO and X_DATA are valid at posedge t+1. This is a one-cycle read latency with no drain stage.
- FSM states: IDLE, LOAD, LDFIN, RUN, FIN.
- IDLE / FIN:
  - LOAD=1 -> LOAD, counter cleared.
  - Else START=1 -> RUN, accumulator loaded with sign-extended BIAS, BRAM_EN=1, BRAM_WE=0, BRAM_ADDR=0.
  - Otherwise -> IDLE.
- RUN:
  - Each posedge: acc <= acc + sext(BRAM_DO * X_DATA), where the 2*DW signed product is sign-extended to ACCW. The multiply is combinational.
  - Address increments each cycle. After DEPTH-1 has been issued, the next edge performs the final accumulate, drops BRAM_EN and enters FIN.
  - Exactly DEPTH accumulates per RUN.
  - START and LOAD are ignored while in RUN.
- FIN:
  - DONE=1 for this single cycle; ACC_OUT valid from this cycle on.
  - START or LOAD sampled here is accepted, allowing back-to-back runs.
  - DONE is asserted DEPTH+1 cycles after the START edge.
- LOAD:
  - LD_READY=1.
  - On each edge with LD_VALID=1: register BRAM_EN=1, BRAM_WE=1, BRAM_ADDR=count, BRAM_DI=LD_DATA, then count++.
  - Edge with LD_VALID=0: BRAM_EN=0, BRAM_WE=0, counter holds (gaps allowed).
  - After the DEPTH-th accepted word -> LDFIN with LD_READY=0; the last write completes at the negedge inside LDFIN.
- LDFIN: BRAM_EN=0, BRAM_WE=0, LD_DONE=1 for one cycle -> IDLE.
- Addresses never exceed DEPTH-1; there is no wrap. Extra LD_VALID outside LOAD is ignored.
- Reset mid-LOAD or mid-RUN:
  - Next cycle: IDLE with EN=WE=0.
  - No DONE or LD_DONE pulse; ACC_OUT cleared.
  - BRAM contents are undefined only for the partial load.
- ACC_OUT is updated only on entry to FIN; it never shows a partial sum.

Test Plan:
- Load W[k]=k+1 with LD_VALID continuous, then RUN with X[k]=1, BIAS=0 -> LD_DONE 28 cycles after the first accept edge + 1; DONE at START+29; ACC_OUT=406.
- RUN with W[k]=-1 (0xFFFF), X[k]=0x7FFF, BIAS=0x8000 -> ACC_OUT = -32768 - 28*32767 = -950244, correctly sign-extended to 40 bits.
- LOAD with LD_VALID toggling 1/0 -> exactly 28 writes at addresses 0..27 in order; BRAM_WE never high on gap cycles; readback RUN matches.
- START and LOAD asserted together in IDLE -> LOAD taken, no accumulate; START pulse during RUN -> ignored, single DONE.
- START held high through FIN -> second RUN begins immediately; two DONE pulses 29 cycles apart, second ACC_OUT correct with its own BIAS.
- RST asserted at RUN cycle 10 -> next cycle BUSY=0, BRAM_EN=0, ACC_OUT=0, no DONE; a following START produces the correct full sum.
